// File: rtl/ibex_multdiv_iter_if.sv
// +----------------------------------------------------------------------------+
// | ibex_multdiv_iter_if                                                       |
// | Request/result handshake bundle between ID/EX and the iterative multdiv.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface ibex_multdiv_iter_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             valid_i;
  logic             ready_o;
  logic [1:0]       operator_i;
  logic [1:0]       signed_mode_i;
  logic [WIDTH-1:0] op_a_i;
  logic [WIDTH-1:0] op_b_i;
  logic             kill_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] result_o;

  modport master (
    output valid_i, operator_i, signed_mode_i, op_a_i, op_b_i, kill_i, ready_i,
    input  ready_o, valid_o, result_o
  );

  modport slave (
    input  valid_i, operator_i, signed_mode_i, op_a_i, op_b_i, kill_i, ready_i,
    output ready_o, valid_o, result_o
  );
endinterface

`default_nettype wire

// File: rtl/ibex_multdiv_iter.sv
// +----------------------------------------------------------------------------+
// | ibex_multdiv_iter                                                          |
// | Iterative shift-add multiplier / restoring divider, one step per cycle.    |
// | Define MULTDIV_ZERO_EXIT_EN to finish DIV/REM by zero straight from IDLE.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module ibex_multdiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  wire                clk_i,
  input  wire                rst_ni,
  ibex_multdiv_iter_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ABS  = 3'd1;
  localparam logic [2:0] S_COMP = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] OP_MULL = 2'd0;
  localparam logic [1:0] OP_MULH = 2'd1;
  localparam logic [1:0] OP_DIV  = 2'd2;
  localparam logic [1:0] OP_REM  = 2'd3;

  logic [2:0]         state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               is_mul;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     add_x, add_y, add_sum;
  logic               add_cin;
  logic [2*WIDTH-1:0] acc_neg;
  logic [WIDTH-1:0]   rem_neg;

  assign is_mul  = ~op_q[1];
  assign abs_a   = sign_a_q ? -a_q : a_q;
  assign abs_b   = sign_b_q ? -b_q : b_q;
  assign acc_neg = -acc_q;
  assign rem_neg = -acc_q[2*WIDTH-1:WIDTH];

  // Shared step adder: multiply adds |a| to the upper half, divide forms
  // (shifted remainder - divisor) whose MSB flags a negative difference.
  always_comb begin
    if (is_mul) begin
      add_x   = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      add_y   = {1'b0, a_q};
      add_cin = 1'b0;
    end else begin
      add_x   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      add_y   = ~{1'b0, b_q};
      add_cin = 1'b1;
    end
    add_sum = add_x + add_y + {{WIDTH{1'b0}}, add_cin};
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    div_zero_d = div_zero_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    result_d   = result_q;

    case (state_q)
      S_IDLE: begin
        if (bus.valid_i && !bus.kill_i) begin
          op_d       = bus.operator_i;
          sign_a_d   = bus.op_a_i[WIDTH-1] & bus.signed_mode_i[0];
          sign_b_d   = bus.op_b_i[WIDTH-1] & bus.signed_mode_i[1];
          a_d        = bus.op_a_i;
          b_d        = bus.op_b_i;
          div_zero_d = (bus.op_b_i == '0);
          state_d    = S_ABS;
`ifdef MULTDIV_ZERO_EXIT_EN
          if (bus.operator_i[1] && (bus.op_b_i == '0)) begin
            result_d = bus.operator_i[0] ? bus.op_a_i : '1;
            state_d  = S_DONE;
          end
`endif
        end
      end

      S_ABS: begin
        a_d     = abs_a;
        b_d     = abs_b;
        acc_d   = is_mul ? {{WIDTH{1'b0}}, abs_b} : {{WIDTH{1'b0}}, abs_a};
        cnt_d   = CW'(WIDTH - 1);
        state_d = S_COMP;
      end

      S_COMP: begin
        if (is_mul) begin
          acc_d = acc_q[0] ? {add_sum, acc_q[WIDTH-1:1]}
                           : {1'b0, acc_q[2*WIDTH-1:1]};
        end else if (!add_sum[WIDTH]) begin
          acc_d = {add_sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_FIX: begin
        case (op_q)
          OP_MULL: result_d = (sign_a_q ^ sign_b_q) ? acc_neg[WIDTH-1:0] : acc_q[WIDTH-1:0];
          OP_MULH: result_d = (sign_a_q ^ sign_b_q) ? acc_neg[2*WIDTH-1:WIDTH]
                                                   : acc_q[2*WIDTH-1:WIDTH];
          // A zero divisor already yields all-ones, which must not be negated.
          OP_DIV:  result_d = (sign_a_q ^ sign_b_q) && !div_zero_q ? acc_neg[WIDTH-1:0]
                                                                   : acc_q[WIDTH-1:0];
          OP_REM:  result_d = sign_a_q ? rem_neg : acc_q[2*WIDTH-1:WIDTH];
          default: result_d = '0;
        endcase
        state_d = S_DONE;
      end

      S_DONE: begin
        if (bus.ready_i) begin
          state_d  = S_IDLE;
          result_d = '0;
        end
      end

      default: begin
        state_d  = S_IDLE;
        result_d = '0;
      end
    endcase

    if ((state_q != S_IDLE) && bus.kill_i) begin
      state_d  = S_IDLE;
      result_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      op_q       <= OP_MULL;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      div_zero_q <= div_zero_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
    end
  end

  assign bus.ready_o  = (state_q == S_IDLE);
  assign bus.valid_o  = (state_q == S_DONE);
  assign bus.result_o = result_q;

endmodule

`default_nettype wire

// File: tb/tb_ibex_multdiv_iter.sv
// +----------------------------------------------------------------------------+
// | tb_ibex_multdiv_iter                                                       |
// | Scoreboard bench for the 32-bit and 8-bit iterative multdiv instances.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ibex_multdiv_iter;

`ifdef MULTDIV_ZERO_EXIT_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 35;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ibex_multdiv_iter_if #(.WIDTH(32)) bus32 ();
  ibex_multdiv_iter_if #(.WIDTH(8))  bus8 ();

  ibex_multdiv_iter #(.WIDTH(32)) u_dut32 (.clk_i(clk), .rst_ni(rst_n), .bus(bus32.slave));
  ibex_multdiv_iter #(.WIDTH(8))  u_dut8  (.clk_i(clk), .rst_ni(rst_n), .bus(bus8.slave));

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [1:0] sm,
                                        input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, r;
    sa = sm[0] ? {{32{a[31]}}, a} : {32'h0, a};
    sb = sm[1] ? {{32{b[31]}}, b} : {32'h0, b};
    case (op)
      2'd0: begin r = sa * sb; return r[31:0]; end
      2'd1: begin r = sa * sb; return r[63:32]; end
      2'd2: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        r = sa / sb; return r[31:0];
      end
      default: begin
        if (b == 32'h0) return a;
        r = sa % sb; return r[31:0];
      end
    endcase
  endfunction

  task automatic run32(input string tag, input logic [1:0] op, input logic [1:0] sm,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat_exp, input int hold);
    int          lat;
    logic [31:0] r;
    @(negedge clk);
    check({tag, " ready_in"}, bus32.ready_o, 1);
    bus32.valid_i       = 1'b1;
    bus32.operator_i    = op;
    bus32.signed_mode_i = sm;
    bus32.op_a_i        = a;
    bus32.op_b_i        = b;
    exp_q.push_back(exp);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      bus32.valid_i = 1'b0;
    end while (!bus32.valid_o && lat < 200);
    check({tag, " latency"}, lat, lat_exp);
    r = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    if (bus32.valid_o) begin
      check({tag, " result"}, bus32.result_o, r);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, " hold"}, {bus32.valid_o, bus32.ready_o, bus32.result_o}, {1'b1, 1'b0, r});
      end
      bus32.ready_i = 1'b1;
      @(negedge clk);
      bus32.ready_i = 1'b0;
      check({tag, " release"}, {bus32.ready_o, bus32.valid_o, bus32.result_o}, {1'b1, 1'b0, 32'h0});
    end
  endtask

  task automatic run8(input string tag, input logic [1:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] exp);
    int lat;
    @(negedge clk);
    bus8.valid_i       = 1'b1;
    bus8.operator_i    = op;
    bus8.signed_mode_i = 2'b11;
    bus8.op_a_i        = a;
    bus8.op_b_i        = b;
    exp_q.push_back({24'h0, exp});
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      bus8.valid_i = 1'b0;
    end while (!bus8.valid_o && lat < 100);
    check({tag, " latency"}, lat, 11);
    if (exp_q.size() > 0) check({tag, " result"}, {24'h0, bus8.result_o}, exp_q.pop_front());
    bus8.ready_i = 1'b1;
    @(negedge clk);
    bus8.ready_i = 1'b0;
    check({tag, " release"}, {bus8.ready_o, bus8.valid_o}, 2'b10);
  endtask

  initial begin
    int          seen;
    logic [1:0]  op, sm;
    logic [31:0] a, b;

    bus32.valid_i = 1'b0; bus32.kill_i = 1'b0; bus32.ready_i = 1'b0;
    bus32.operator_i = 2'd0; bus32.signed_mode_i = 2'd0; bus32.op_a_i = '0; bus32.op_b_i = '0;
    bus8.valid_i = 1'b0; bus8.kill_i = 1'b0; bus8.ready_i = 1'b0;
    bus8.operator_i = 2'd0; bus8.signed_mode_i = 2'd0; bus8.op_a_i = '0; bus8.op_b_i = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset32", {bus32.ready_o, bus32.valid_o, bus32.result_o}, {1'b1, 1'b0, 32'h0});
    check("reset8", {bus8.ready_o, bus8.valid_o, bus8.result_o}, {1'b1, 1'b0, 8'h0});
    rst_n = 1'b1;

    run32("mull_7x-3",  2'd0, 2'd3, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 35, 0);
    run32("mulh_min2",  2'd1, 2'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35, 0);
    run32("mulh_uu",    2'd1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35, 0);
    run32("mulh_su",    2'd1, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35, 0);
    run32("div_-7/2",   2'd2, 2'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 35, 0);
    run32("rem_-7%2",   2'd3, 2'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 35, 0);
    run32("div_min/-1", 2'd2, 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35, 0);
    run32("rem_min/-1", 2'd3, 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         35, 0);
    run32("divu",       2'd2, 2'd0, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 35, 0);
    run32("remu",       2'd3, 2'd0, 32'hFFFF_FFFF, 32'h10,        32'hF,         35, 0);
    run32("div_by0",    2'd2, 2'd3, 32'hFFFF_FFFB, 32'h0,         32'hFFFF_FFFF, ZLAT, 0);
    run32("rem_by0",    2'd3, 2'd3, 32'hFFFF_FFFB, 32'h0,         32'hFFFF_FFFB, ZLAT, 0);
    run32("backpress",  2'd2, 2'd0, 32'd1000,      32'd7,         32'd142,       35, 10);

    // Abort in the tenth COMP cycle (cycle 11 after accept).
    @(negedge clk);
    bus32.valid_i = 1'b1; bus32.operator_i = 2'd2; bus32.signed_mode_i = 2'd0;
    bus32.op_a_i = 32'd100; bus32.op_b_i = 32'd7;
    @(posedge clk);
    repeat (11) begin @(negedge clk); bus32.valid_i = 1'b0; end
    bus32.kill_i = 1'b1;
    @(negedge clk);
    bus32.kill_i = 1'b0;
    check("kill idle", {bus32.ready_o, bus32.valid_o}, 2'b10);
    seen = 0;
    repeat (40) begin @(negedge clk); if (bus32.valid_o) seen = 1; end
    check("kill no result", seen, 0);
    run32("post_kill", 2'd3, 2'd0, 32'd100, 32'd7, 32'd2, 35, 0);

    // Reset in the middle of a divide.
    @(negedge clk);
    bus32.valid_i = 1'b1; bus32.operator_i = 2'd2; bus32.signed_mode_i = 2'd3;
    bus32.op_a_i = 32'd12345; bus32.op_b_i = 32'd3;
    @(posedge clk);
    repeat (15) begin @(negedge clk); bus32.valid_i = 1'b0; end
    rst_n = 1'b0;
    @(negedge clk);
    check("mid reset", {bus32.ready_o, bus32.valid_o, bus32.result_o}, {1'b1, 1'b0, 32'h0});
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      op = 2'($urandom_range(0, 3));
      sm = 2'($urandom_range(0, 3));
      a  = $urandom();
      b  = (i % 4 == 3) ? 32'h0 : ((i % 2 == 0) ? $urandom() : 32'($urandom_range(1, 300)));
      run32("rand", op, sm, a, b, model(op, sm, a, b),
            (op[1] && b == 32'h0) ? ZLAT : 35, i % 3);
    end

    run8("w8_mulh", 2'd1, 8'h80, 8'h7F, 8'hC0);
    run8("w8_div",  2'd2, 8'h80, 8'hFF, 8'h80);
    run8("w8_rem",  2'd3, 8'hF9, 8'h02, 8'hFF);

    check("queue empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
